lcd_instr_writer: RTL and testbench
===================================

Name: lcd_instr_writer

Overview:
- Parametrised successor to the LCD instruction sequencer: accepts one LCD instruction or data byte per valid/ready handshake and drives the character-LCD bus with programmable setup, enable-pulse, hold, inter-nibble and post-command wait times.
- Supports a 4-bit bus (two nibble transfers, high nibble first) or an 8-bit bus (one transfer), plus a per-command long wait for slow instructions such as clear and home.
- Sits between the init/display-control FSMs and the LCD pins.

Parameters:
- BUS_W, 4, LCD data bus width; legal values 4 or 8.
- SETUP_CYC, 2, cycles RS/RW/data are stable before E rises; >=1.
- PULSE_CYC, 12, cycles E is high; >=1.
- HOLD_CYC, 1, cycles data is held after E falls; >=1.
- NIBBLE_GAP, 50, cycles between high-nibble hold end and low-nibble setup start (4-bit mode only); >=1.
- POST_WAIT, 2000, cycles after final hold before done; >=1.
- LONG_WAIT, 82000, post wait used when cmd_long=1; >=1.
- CNT_W, 20, internal delay counter width; must hold max(all cycle parameters).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_rs  input  1  register select for the command (0 instruction, 1 data).
- cmd_rw  input  1  read/write for the command.
- cmd_data  input  8  instruction or data byte.
- cmd_long  input  1  use LONG_WAIT instead of POST_WAIT.
- LCD_RS  output  1  LCD register select.
- LCD_RW  output  1  LCD read/write.
- LCD_E  output  1  LCD enable strobe.
- SF_D  output  BUS_W  LCD data bus.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse on command completion.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset_n=0, all outputs are 0, including cmd_ready, busy, done, LCD_E, LCD_RS, LCD_RW and SF_D; the state is forced to IDLE and the counter to 0, with immediate effect.
- All outputs are registered. Each output changes on the same edge that enters the state driving it.
- States: IDLE, SETUP, ACTIVE, HOLD, GAP, WAIT. A phase bit selects the high or low nibble.
- IDLE:
  - cmd_ready=1, busy=0, E=0, RS=0, RW=0, SF_D=0.
  - When cmd_valid=1 on an edge, cmd_rs, cmd_rw, cmd_data and cmd_long are latched and the state goes to SETUP with phase=HIGH.
  - cmd_ready and done are not checked again until the block returns to IDLE.
- SETUP (SETUP_CYC cycles): E=0; RS/RW from the latched command.
  - 4-bit mode: SF_D = data[7:4] in phase HIGH, data[3:0] in phase LOW.
  - 8-bit mode: SF_D = data[7:0].
- ACTIVE (PULSE_CYC cycles): E=1; RS, RW and SF_D unchanged.
- HOLD (HOLD_CYC cycles): E=0; RS, RW and SF_D unchanged.
  - 4-bit, phase HIGH: next state is GAP.
  - Otherwise: next state is WAIT.
- GAP (NIBBLE_GAP cycles): E=0, RS/RW held, SF_D held. Then SETUP with phase=LOW.
- WAIT (LONG_WAIT cycles if the latched cmd_long=1, else POST_WAIT): E=0, RS/RW held, SF_D held.
  - On exit, go to IDLE with done=1 for exactly that first IDLE cycle.
  - cmd_ready=1 in the same cycle, so back-to-back commands are allowed: a command presented then is accepted on that edge.
- Latency, from accept edge to done-high edge:
  - 4-bit: 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+NIBBLE_GAP+WAIT_LEN. With defaults this is 2080.
  - 8-bit: SETUP_CYC+PULSE_CYC+HOLD_CYC+WAIT_LEN.
- The counter resets to 0 on each state entry. A state is left when counter = length-1.
- Changes on cmd_* while busy are ignored.
- busy = ~cmd_ready after reset is released.

Test Plan:
- Defaults, 4-bit. Accept cmd_data=0x28, rs=0, rw=0 at edge T0 -> E high for 12 cycles from T0+2 with SF_D=0x2; E high for 12 cycles from T0+67 with SF_D=0x8; done pulse at T0+2080; exactly two E pulses.
- cmd_long=1, cmd_data=0x01 -> done at T0+80+82000; no E activity during WAIT.
- BUS_W=8, cmd_rs=1, cmd_data=0x41 -> single E pulse with SF_D=0x41 and LCD_RS=1 throughout; done at T0+15+2000.
- Back-to-back: cmd_valid held high with two commands -> second accepted on the done cycle; done pulses 2080 cycles apart; cmd_ready low in between.
- Drive reset_n=0 mid-ACTIVE (E=1) -> E, SF_D, busy and cmd_ready drop asynchronously to 0; after release, cmd_ready=1 on the first edge and no stale done.
- cmd_data changed while busy -> SF_D shows the latched value only.

Source files
------------

// File: rtl/lcd_instr_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_instr_writer_if
//
// Command channel between the init/display-control FSMs and the LCD
// instruction writer. One command is transferred per valid/ready handshake;
// busy and done report progress of the command currently on the LCD bus.
//
// Signals:
//   cmd_valid  requester -> writer  command present
//   cmd_ready  writer -> requester  writer is idle and can take a command
//   cmd_rs     requester -> writer  register select (0 instruction, 1 data)
//   cmd_rw     requester -> writer  read/write strobe level for the command
//   cmd_data   requester -> writer  instruction or data byte
//   cmd_long   requester -> writer  use the long post-command wait
//   busy       writer -> requester  high from accept until done
//   done       writer -> requester  one-cycle pulse on command completion
//
// Modports:
//   master  the command source (init or display-control FSM)
//   slave   the LCD instruction writer
// ---------------------------------------------------------------------------
interface lcd_instr_writer_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rs;
   logic       cmd_rw;
   logic [7:0] cmd_data;
   logic       cmd_long;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid,
      output cmd_rs,
      output cmd_rw,
      output cmd_data,
      output cmd_long,
      input  cmd_ready,
      input  busy,
      input  done
   );

   modport slave (
      input  cmd_valid,
      input  cmd_rs,
      input  cmd_rw,
      input  cmd_data,
      input  cmd_long,
      output cmd_ready,
      output busy,
      output done
   );

endinterface

// File: rtl/lcd_instr_writer.sv
// ---------------------------------------------------------------------------
// lcd_instr_writer
//
// Accepts one character-LCD instruction or data byte per handshake on the
// command interface and plays it out on the LCD pins with programmable
// setup, enable-pulse, hold, inter-nibble and post-command wait times.
// In 4-bit mode the byte is sent as two nibble transfers, high nibble first;
// in 8-bit mode it is sent in a single transfer. Slow instructions such as
// clear and home request the long post-command wait through cmd_long.
//
// Parameters:
//   BUS_W       LCD data bus width, 4 or 8
//   SETUP_CYC   cycles RS/RW/data are stable before E rises
//   PULSE_CYC   cycles E is high
//   HOLD_CYC    cycles data is held after E falls
//   NIBBLE_GAP  cycles between the two nibble transfers (4-bit only)
//   POST_WAIT   cycles after the final hold before done
//   LONG_WAIT   post wait used when the command asked for it
//   CNT_W       delay counter width, must hold every cycle parameter
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   cmd      command interface (slave side): valid/ready, rs, rw, data,
//            long, busy, done
//   LCD_RS   LCD register select
//   LCD_RW   LCD read/write
//   LCD_E    LCD enable strobe
//   SF_D     LCD data bus
//
// Every output is a register that changes on the edge entering the state
// that defines it, so the LCD pins never glitch between states.
// ---------------------------------------------------------------------------
module lcd_instr_writer #(
   parameter int BUS_W      = 4,
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 12,
   parameter int HOLD_CYC   = 1,
   parameter int NIBBLE_GAP = 50,
   parameter int POST_WAIT  = 2000,
   parameter int LONG_WAIT  = 82000,
   parameter int CNT_W      = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   lcd_instr_writer_if.slave  cmd,
   output logic               LCD_RS,
   output logic               LCD_RW,
   output logic               LCD_E,
   output logic [BUS_W-1:0]   SF_D
);

   // Any width other than 8 is treated as the 4-bit nibble bus.
   localparam bit FOUR_BIT = (BUS_W != 8);

   // Each state is left when the counter reaches its length minus one.
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NIBBLE_GAP - 1);
   localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_WAIT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACTIVE,
      HOLD,
      GAP,
      WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             phase_low;
   logic [7:0]       data_q;
   logic             long_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] wait_last;

   // Value placed on the data bus for a given byte and nibble phase. In
   // 8-bit mode the phase is irrelevant and the whole byte is driven.
   function automatic logic [BUS_W-1:0] bus_value(input logic [7:0] byte_in,
                                                  input logic       low);
      logic [7:0] aligned;
      aligned = (FOUR_BIT && !low) ? {4'h0, byte_in[7:4]} : byte_in;
      return aligned[BUS_W-1:0];
   endfunction

   // The post-command wait length is chosen by the latched long flag, so a
   // requester changing cmd_long mid-command cannot stretch or cut the wait.
   assign wait_last = long_q ? LONG_LAST : POST_LAST;

   assign cmd.cmd_ready = ready_q;
   assign cmd.busy      = busy_q;
   assign cmd.done      = done_q;

   // Sequencer: one register block holds the state, the shared delay
   // counter, the latched command and every output. Outputs are assigned on
   // the transition into the state that defines them. While reset_n is low
   // everything, including cmd_ready, is held at zero; cmd_ready rises on
   // the first edge after release, and a command is taken only on an edge
   // where cmd_ready was already high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         phase_low <= 1'b0;
         data_q    <= '0;
         long_q    <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         LCD_RS    <= 1'b0;
         LCD_RW    <= 1'b0;
         LCD_E     <= 1'b0;
         SF_D      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (cmd.cmd_valid && ready_q) begin
                  state     <= SETUP;
                  phase_low <= 1'b0;
                  data_q    <= cmd.cmd_data;
                  long_q    <= cmd.cmd_long;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  LCD_RS    <= cmd.cmd_rs;
                  LCD_RW    <= cmd.cmd_rw;
                  LCD_E     <= 1'b0;
                  SF_D      <= bus_value(cmd.cmd_data, 1'b0);
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  LCD_RS  <= 1'b0;
                  LCD_RW  <= 1'b0;
                  LCD_E   <= 1'b0;
                  SF_D    <= '0;
               end
            end

            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= ACTIVE;
                  cnt   <= '0;
                  LCD_E <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ACTIVE: begin
               if (cnt == PULSE_LAST) begin
                  state <= HOLD;
                  cnt   <= '0;
                  LCD_E <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // After the high nibble of a 4-bit transfer the bus rests for
            // the nibble gap; otherwise the command is complete on the bus
            // and only the post-command wait remains.
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  if (FOUR_BIT && !phase_low) begin
                     state <= GAP;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // The low nibble is put on the bus on the edge entering SETUP so
            // it is stable for the full setup time.
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state     <= SETUP;
                  cnt       <= '0;
                  phase_low <= 1'b1;
                  SF_D      <= bus_value(data_q, 1'b1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Leaving WAIT lands in IDLE with cmd_ready already high, which
            // lets a waiting requester hand over its next command on the
            // very edge that ends the done cycle.
            WAIT: begin
               if (cnt == wait_last) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  LCD_RS  <= 1'b0;
                  LCD_RW  <= 1'b0;
                  LCD_E   <= 1'b0;
                  SF_D    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= IDLE;
               cnt     <= '0;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               LCD_RS  <= 1'b0;
               LCD_RW  <= 1'b0;
               LCD_E   <= 1'b0;
               SF_D    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_instr_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_instr_writer
//
// Two writers share clock and reset: dut A is a 4-bit bus with the default
// timings (long wait shortened to keep the run brief), dut B is an 8-bit bus
// with short timings. Stimulus is routed to one dut at a time through sel.
// The expected pin trace of every command is computed from the timing rules
// as a window arithmetic on the cycle index after the accept edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_instr_writer;

   localparam int SETUP_P [2] = '{2, 3};
   localparam int PULSE_P [2] = '{12, 4};
   localparam int HOLD_P  [2] = '{1, 2};
   localparam int GAP_P   [2] = '{50, 5};
   localparam int POST_P  [2] = '{2000, 20};
   localparam int LONG_P  [2] = '{3000, 60};
   localparam bit BUS8_P  [2] = '{1'b0, 1'b1};

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       done;
      logic       e;
      logic       rs;
      logic       rw;
      logic [7:0] sfd;
   } obs_t;

   typedef struct {
      int         dut;
      bit         rs;
      bit         rw;
      logic [7:0] data;
      bit         lng;
      logic [7:0] expFirst;
      logic [7:0] expSecond;
      int         expPulses;
      int         expLatency;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   int         sel;
   logic       vValid;
   logic       vRs;
   logic       vRw;
   logic       vLong;
   logic [7:0] vData;
   int         checks = 0;
   int         passes = 0;

   logic       lcdRsA, lcdRwA, lcdEA;
   logic [3:0] sfdA;
   logic       lcdRsB, lcdRwB, lcdEB;
   logic [7:0] sfdB;
   obs_t       obs;

   always #5 clk = ~clk;

   lcd_instr_writer_if ifA ();
   lcd_instr_writer_if ifB ();

   assign ifA.cmd_valid = vValid && (sel == 0);
   assign ifA.cmd_rs    = vRs;
   assign ifA.cmd_rw    = vRw;
   assign ifA.cmd_data  = vData;
   assign ifA.cmd_long  = vLong;
   assign ifB.cmd_valid = vValid && (sel == 1);
   assign ifB.cmd_rs    = vRs;
   assign ifB.cmd_rw    = vRw;
   assign ifB.cmd_data  = vData;
   assign ifB.cmd_long  = vLong;

   lcd_instr_writer #(
      .BUS_W(4), .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(1),
      .NIBBLE_GAP(50), .POST_WAIT(2000), .LONG_WAIT(3000), .CNT_W(20)
   ) dutA (
      .clk(clk), .reset_n(reset_n), .cmd(ifA),
      .LCD_RS(lcdRsA), .LCD_RW(lcdRwA), .LCD_E(lcdEA), .SF_D(sfdA)
   );

   lcd_instr_writer #(
      .BUS_W(8), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2),
      .NIBBLE_GAP(5), .POST_WAIT(20), .LONG_WAIT(60), .CNT_W(8)
   ) dutB (
      .clk(clk), .reset_n(reset_n), .cmd(ifB),
      .LCD_RS(lcdRsB), .LCD_RW(lcdRwB), .LCD_E(lcdEB), .SF_D(sfdB)
   );

   // Observed pins of the selected dut, data bus zero-extended to a byte.
   always_comb begin
      obs = '0;
      if (sel == 0) begin
         obs.ready = ifA.cmd_ready;
         obs.busy  = ifA.busy;
         obs.done  = ifA.done;
         obs.e     = lcdEA;
         obs.rs    = lcdRsA;
         obs.rw    = lcdRwA;
         obs.sfd   = {4'h0, sfdA};
      end else begin
         obs.ready = ifB.cmd_ready;
         obs.busy  = ifB.busy;
         obs.done  = ifB.done;
         obs.e     = lcdEB;
         obs.rs    = lcdRsB;
         obs.rw    = lcdRwB;
         obs.sfd   = sfdB;
      end
   end

   function automatic int totalCycles(input int d, input bit lng);
      int len, nib;
      len = SETUP_P[d] + PULSE_P[d] + HOLD_P[d];
      nib = BUS8_P[d] ? 1 : 2;
      return nib * len + (nib - 1) * GAP_P[d] + (lng ? LONG_P[d] : POST_P[d]);
   endfunction

   // Expected pins k cycles after the accept edge (k = 0 is the cycle that
   // follows the accept edge).
   function automatic obs_t modelAt(input int d, input int k, input bit rs,
                                    input bit rw, input logic [7:0] data,
                                    input bit lng);
      obs_t o;
      int   len, off, total;
      o     = '0;
      len   = SETUP_P[d] + PULSE_P[d] + HOLD_P[d];
      total = totalCycles(d, lng);
      if (k >= total) begin
         o.ready = 1'b1;
         o.done  = (k == total);
         return o;
      end
      o.busy = 1'b1;
      o.rs   = rs;
      o.rw   = rw;
      if (BUS8_P[d]) begin
         o.sfd = data;
         off   = k;
      end else if (k < len + GAP_P[d]) begin
         o.sfd = {4'h0, data[7:4]};
         off   = k;
      end else begin
         o.sfd = {4'h0, data[3:0]};
         off   = k - len - GAP_P[d];
      end
      o.e = (off >= SETUP_P[d]) && (off < SETUP_P[d] + PULSE_P[d]);
      return o;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Wait (bounded) for the selected dut to be ready, present the command
   // and return just after the accept edge.
   task automatic applyStimulus(input int d, input bit rs, input bit rw,
                                input logic [7:0] data, input bit lng,
                                output bit ok);
      ok = 1'b0;
      @(negedge clk);
      sel = d;
      #1;
      for (int i = 0; i < 5000; i++) begin
         if (obs.ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) begin
         checkOutput("ready before command", 0, 1);
         return;
      end
      vRs    = rs;
      vRw    = rw;
      vData  = data;
      vLong  = lng;
      vValid = 1'b1;
      @(posedge clk);
   endtask

   // Play one command, scramble the command inputs while it runs, compare
   // every cycle against the model and report the measured pulse data.
   task automatic runCommand(input int d, input bit rs, input bit rw,
                             input logic [7:0] data, input bit lng,
                             input string name,
                             output logic [7:0] first, output logic [7:0] second,
                             output int pulses, output int latency);
      bit   ok;
      bit   prevE;
      int   bad;
      int   total;
      obs_t act;
      obs_t exp;
      obs_t badAct;
      obs_t badExp;
      first   = '0;
      second  = '0;
      pulses  = 0;
      latency = -1;
      applyStimulus(d, rs, rw, data, lng, ok);
      if (!ok) return;
      total  = totalCycles(d, lng);
      bad    = -1;
      prevE  = 1'b0;
      badAct = '0;
      badExp = '0;
      for (int k = 0; k <= total + 1; k++) begin
         @(negedge clk);
         vValid = 1'b0;
         vData  = 8'($urandom);
         vRs    = 1'($urandom);
         vRw    = 1'($urandom);
         vLong  = 1'($urandom);
         #1;
         act = obs;
         exp = modelAt(d, k, rs, rw, data, lng);
         if (act != exp && bad < 0) begin
            bad    = k;
            badAct = act;
            badExp = exp;
         end
         if (act.e && !prevE) begin
            pulses++;
            if (pulses == 1) first = act.sfd;
            else second = act.sfd;
         end
         prevE = act.e;
         if (act.done && latency < 0) latency = k;
      end
      if (bad >= 0)
         $display("[TB] %s cycle %0d pins got %h, model %h", name, bad, badAct, badExp);
      checkOutput({name, " trace first bad cycle"}, bad, -1);
   endtask

   vec_t vecs [5];

   initial begin
      bit         ok;
      logic [7:0] first, second;
      int         pulses, latency, d1, d2, leak, doneSeen;
      bit         firstE;
      logic [7:0] sfd2;

      vecs[0] = '{0, 1'b0, 1'b0, 8'h28, 1'b0, 8'h02, 8'h08, 2, 2080};
      vecs[1] = '{0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 8'h01, 2, 3080};
      vecs[2] = '{1, 1'b1, 1'b0, 8'h41, 1'b0, 8'h41, 8'h00, 1, 29};
      vecs[3] = '{1, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 8'h00, 1, 69};
      vecs[4] = '{0, 1'b1, 1'b1, 8'hF3, 1'b0, 8'h0F, 8'h03, 2, 2080};

      sel     = 0;
      vValid  = 1'b0;
      vRs     = 1'b0;
      vRw     = 1'b0;
      vLong   = 1'b0;
      vData   = 8'h00;
      reset_n = 1'b0;

      // Reset state of both duts.
      #1;
      checkOutput("reset pins dut A", int'(obs), 0);
      sel = 1;
      #1;
      checkOutput("reset pins dut B", int'(obs), 0);
      sel = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("ready after reset release", int'(obs.ready), 1);
      checkOutput("busy after reset release", int'(obs.busy), 0);

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         runCommand(vecs[i].dut, vecs[i].rs, vecs[i].rw, vecs[i].data, vecs[i].lng,
                    $sformatf("vec%0d", i), first, second, pulses, latency);
         checkOutput($sformatf("vec%0d E pulses", i), pulses, vecs[i].expPulses);
         checkOutput($sformatf("vec%0d first nibble", i), int'(first), int'(vecs[i].expFirst));
         if (vecs[i].expPulses == 2)
            checkOutput($sformatf("vec%0d second nibble", i), int'(second), int'(vecs[i].expSecond));
         checkOutput($sformatf("vec%0d done latency", i), latency, vecs[i].expLatency);
      end

      // Back-to-back: valid stays high, second command taken on the done cycle.
      applyStimulus(0, 1'b0, 1'b0, 8'h28, 1'b0, ok);
      if (ok) begin
         #1;
         vData = 8'h0C;
         vRs   = 1'b1;
         d1    = -1;
         d2    = -1;
         leak  = 0;
         for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            #1;
            if (obs.done) begin
               d1 = k;
               break;
            end
            if (obs.ready) leak++;
         end
         checkOutput("b2b first done latency", d1, 2080);
         firstE = 1'b1;
         sfd2   = 8'hFF;
         for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            #1;
            if (k == 0) begin
               checkOutput("b2b accepted on done cycle", int'(obs.busy), 1);
               checkOutput("b2b second rs latched", int'(obs.rs), 1);
               vValid = 1'b0;
               vData  = 8'h99;
            end
            if (obs.e && firstE) begin
               sfd2   = obs.sfd;
               firstE = 1'b0;
            end
            if (obs.done) begin
               d2 = k;
               break;
            end
            if (obs.ready) leak++;
         end
         checkOutput("b2b second done latency", d2, 2080);
         checkOutput("b2b ready low while busy", leak, 0);
         checkOutput("b2b second high nibble", int'(sfd2), 0);
      end

      // Asynchronous reset in the middle of an enable pulse.
      applyStimulus(0, 1'b1, 1'b0, 8'hC5, 1'b0, ok);
      if (ok) begin
         for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            vValid = 1'b0;
         end
         #1;
         checkOutput("E high before reset", int'(obs.e), 1);
         checkOutput("SF_D before reset", int'(obs.sfd), 12);
         reset_n = 1'b0;
         #1;
         checkOutput("async reset E", int'(obs.e), 0);
         checkOutput("async reset SF_D", int'(obs.sfd), 0);
         checkOutput("async reset busy", int'(obs.busy), 0);
         checkOutput("async reset ready", int'(obs.ready), 0);
         checkOutput("async reset RS", int'(obs.rs), 0);
         @(negedge clk);
         @(negedge clk);
         reset_n = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("ready on first edge after reset", int'(obs.ready), 1);
         doneSeen = 0;
         for (int k = 0; k < 20; k++) begin
            if (obs.done || obs.e) doneSeen++;
            @(negedge clk);
            #1;
         end
         checkOutput("no stale done or E after reset", doneSeen, 0);
      end

      // Randomised commands against the model.
      for (int i = 0; i < 8; i++) begin
         int         d;
         bit         rs, rw, lng;
         logic [7:0] data;
         d    = (i < 2) ? 0 : 1;
         rs   = 1'($urandom);
         rw   = 1'($urandom);
         lng  = (d == 1) ? 1'($urandom) : 1'b0;
         data = 8'($urandom);
         runCommand(d, rs, rw, data, lng, $sformatf("rand%0d", i),
                    first, second, pulses, latency);
         checkOutput($sformatf("rand%0d E pulses", i), pulses, BUS8_P[d] ? 1 : 2);
         checkOutput($sformatf("rand%0d done latency", i), latency, totalCycles(d, lng));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
